// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcode map and
// issue FSM state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } issue_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, or, subtract, xor on w-bit operands.
// Carry and borrow are dropped.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned w = 8
) (
  input  logic [1:0]   opcode,
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] out
);

  always_comb begin
    out = '0;
    unique case (opcode)
      ALU_ADD: out = a + b;
      ALU_OR:  out = a | b;
      ALU_SUB: out = a - b;
      ALU_XOR: out = a ^ b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU issue controller. Head entry is shown on rdata
// whenever the FIFO is not empty; full/empty decode a registered occupancy count.
module alu_req_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational alu: buffers requests, issues one at a
// time on registered ALU inputs and returns results in order. ALU_ISSUE_STATS_EN adds op_count.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_opcode,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_opcode,
  input  logic [W-1:0] alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_opcode
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]  op_count
`endif
);

  localparam int unsigned DW = 2 * W + 2;

  issue_state_e  state_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_rdata;

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && req_ready;
  assign fifo_pop   = (state_q == StIdle) && !fifo_empty;
  assign fifo_wdata = {req_opcode, req_a, req_b};

  alu_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU input registers change only on a pop, so alu_out is stable throughout EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            alu_opcode <= fifo_rdata[DW-1 -: 2];
            alu_a      <= fifo_rdata[2*W-1 -: W];
            alu_b      <= fifo_rdata[W-1:0];
            state_q    <= StExec;
          end
        end
        StExec: begin
          res_data   <= alu_out;
          res_opcode <= alu_opcode;
          res_valid  <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (res_valid && res_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving the combinational alu.
// Checks op_count as well when ALU_ISSUE_STATS_EN is defined.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NV    = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_opcode = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_opcode;
  logic [W-1:0] alu_out;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic [1:0]   res_opcode;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]  op_count;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  alu #(
    .w (W)
  ) u_alu (
    .opcode (alu_opcode),
    .a      (alu_a),
    .b      (alu_b),
    .out    (alu_out)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [NV];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check({tag, " alu_a"}, 32'(alu_a), 32'd0);
    check({tag, " alu_b"}, 32'(alu_b), 32'd0);
    check({tag, " alu_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, " res_data"}, 32'(res_data), 32'd0);
    check({tag, " res_opcode"}, 32'(res_opcode), 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check({tag, " op_count"}, 32'(op_count), 32'd0);
`endif
  endtask

  initial begin
    logic [1:0]   ord_op  [3];
    logic [W-1:0] ord_a   [3];
    logic [W-1:0] ord_b   [3];
    logic [W-1:0] ord_exp [3];
    int           got;
    int           accepted;
    int           seen;
    int           last_cyc;
    logic         go;
    logic         hs;
    logic         unstable;
    logic [W-1:0] data;

    vecs[0] = '{"add",      ALU_ADD, 8'h0F, 8'h01, 8'h10};
    vecs[1] = '{"add_wrap", ALU_ADD, 8'hFF, 8'h02, 8'h01};
    vecs[2] = '{"sub_wrap", ALU_SUB, 8'h01, 8'h02, 8'hFF};
    vecs[3] = '{"or",       ALU_OR,  8'hF0, 8'h0F, 8'hFF};
    vecs[4] = '{"xor",      ALU_XOR, 8'hAA, 8'hFF, 8'h55};
    vecs[5] = '{"sub",      ALU_SUB, 8'h05, 8'h03, 8'h02};
    vecs[6] = '{"add_zero", ALU_ADD, 8'h80, 8'h80, 8'h00};
    vecs[7] = '{"sub_neg",  ALU_SUB, 8'h00, 8'h01, 8'hFF};

    ord_op  = '{ALU_OR, ALU_XOR, ALU_SUB};
    ord_a   = '{8'hF0, 8'hAA, 8'h05};
    ord_b   = '{8'h0F, 8'hFF, 8'h03};
    ord_exp = '{8'hFF, 8'h55, 8'h02};

    // Reset state
    #2;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single requests with res_ready held: valid two edges after acceptance
    res_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      req_opcode = vecs[i].op;
      req_a      = vecs[i].a;
      req_b      = vecs[i].b;
      req_valid  = 1'b1;
      check({vecs[i].name, " req_ready"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      check({vecs[i].name, " valid_n"}, 32'(res_valid), 32'd0);
      tick();
      check({vecs[i].name, " valid_n1"}, 32'(res_valid), 32'd0);
      check({vecs[i].name, " alu_a"}, 32'(alu_a), 32'(vecs[i].a));
      check({vecs[i].name, " alu_b"}, 32'(alu_b), 32'(vecs[i].b));
      tick();
      check({vecs[i].name, " valid_n2"}, 32'(res_valid), 32'd1);
      check({vecs[i].name, " data"}, 32'(res_data), 32'(vecs[i].exp));
      check({vecs[i].name, " opcode"}, 32'(res_opcode), 32'(vecs[i].op));
      tick();
      check({vecs[i].name, " valid_clear"}, 32'(res_valid), 32'd0);
    end

    // Ordering: three back-to-back pushes, results at edges 2, 5, 8
    got = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 3) begin
        req_opcode = ord_op[cyc];
        req_a      = ord_a[cyc];
        req_b      = ord_b[cyc];
        req_valid  = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (res_valid) begin
        if (got < 3) begin
          check($sformatf("order data %0d", got), 32'(res_data), 32'(ord_exp[got]));
          check($sformatf("order cycle %0d", got), 32'(cyc), 32'(2 + 3 * got));
        end
        got++;
        last_cyc = cyc;
      end
    end
    check("order count", 32'(got), 32'd3);

    // Back-pressure: one in flight plus DEPTH buffered, then req_ready drops
    res_ready = 1'b0;
    req_valid = 1'b1;
    accepted  = 0;
    unstable  = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      req_opcode = ALU_ADD;
      req_a      = 8'h10 + 8'(accepted);
      req_b      = 8'h01;
      go         = req_ready;
      tick();
      if (go) accepted++;
      if (cyc >= 2 && (!res_valid || res_data !== 8'h11)) unstable = 1'b1;
    end
    req_valid = 1'b0;
    check("full accepted", 32'(accepted), 32'(DEPTH + 1));
    check("full req_ready", 32'(req_ready), 32'd0);
    check("full hold valid", 32'(res_valid), 32'd1);
    check("full hold stable", 32'(unstable), 32'd0);
    check("full hold data", 32'(res_data), 32'h11);

    res_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      hs   = res_valid;
      data = res_data;
      tick();
      if (hs) begin
        check($sformatf("drain data %0d", got), 32'(data), 32'(8'h11 + 8'(got)));
        got++;
      end
    end
    check("drain count", 32'(got), 32'd5);
    tick();

    // Reset while in EXEC with three entries buffered
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_opcode = ALU_XOR;
      req_a      = 8'h30 + 8'(i);
      req_b      = 8'h0C;
      req_valid  = 1'b1;
      check($sformatf("rst push ready %0d", i), 32'(req_ready), 32'd1);
      tick();
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("exec alu_a", 32'(alu_a), 32'h31);
    check("exec alu_opcode", 32'(alu_opcode), 32'(ALU_XOR));
`ifdef ALU_ISSUE_STATS_EN
    check("op_count", 32'(op_count), 32'(NV + 3 + 5 + 1));
`endif
    rst = 1'b1;
    #1;
    check_reset_outputs("midop");
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (res_valid) seen++;
    end
    check("post rst results", 32'(seen), 32'd0);
    check("post rst alu_a", 32'(alu_a), 32'd0);
    check("post rst req_ready", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
